famicom_pad_emulator: RTL and testbench
=======================================

Name: famicom_pad_emulator

Overview:
- Emulates a Famicom/NES serial game controller for the Gigatron shell.
- Consumes the shell's `famicom_latch` and `famicom_pulse` outputs and drives its `famicom_data` input from the host joystick word.
- Sits directly upstream of the shell's controller port, in the `clk_sys` domain.
- The latch/pulse strobes originate in the slower Gigatron clock domain and are resynchronised here.

Parameters:
- FILL_BIT, 1'b1: level driven on `famicom_data` after all 8 buttons have been shifted out (1 = released).
- TURBO_DIV, 4: number of latch polls per turbo phase toggle (used only with TURBO_EN).

Ports:
- clk_sys  in  1  system clock; all state is registered on its rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- joy_in  in  8  host buttons, active-high; bit0 R, 1 L, 2 D, 3 U, 4 A, 5 B, 6 Select, 7 Start.
- turbo_in  in  2  active-high turbo requests; bit0 turbo-A, bit1 turbo-B. Ignored without TURBO_EN.
- famicom_latch  in  1  parallel-load strobe from the shell, asynchronous to `clk_sys`.
- famicom_pulse  in  1  shift clock from the shell, asynchronous to `clk_sys`.
- famicom_data  out  1  serial button data, active-low (pressed = 0).
- bit_count  out  4  number of shifts since the last latch, saturating at 8.
- poll_strobe  out  1  one-cycle pulse on each synchronised latch falling edge.

Behaviour:
- Synchronisers:
  - `famicom_latch` and `famicom_pulse` each pass through a 2-FF synchroniser plus one history FF.
  - Rising and falling edges are detected on the synchronised value.
- Shift register `shreg[7:0]` holds active-low data in serial order: bit0 A, 1 B, 2 Select, 3 Start, 4 Up, 5 Down, 6 Left, 7 Right.
- `famicom_data` = `shreg[0]`, driven directly from the register with no combinational path from inputs.
- Load state (synchronised latch high):
  - Every cycle, `shreg` <= inverted, reordered `joy_in`; `bit_count` <= 0.
  - The register is transparent, so `joy_in` changes during latch-high are tracked.
- Shift state (synchronised latch low): on a synchronised pulse rising edge, `shreg` <= {FILL_BIT, shreg[7:1]} and `bit_count` <= min(bit_count+1, 8).
- Pulse edge while latch is high: ignored; load wins.
- Pulse edge in the same cycle as the latch falling edge: the load completes and the pulse is ignored.
- Shifts beyond 8: `shreg` keeps shifting, so `famicom_data` = FILL_BIT. `bit_count` holds at 8 and never wraps.
- `poll_strobe`: asserted for exactly one cycle on the synchronised latch falling edge.
- Latency: a raw edge on latch or pulse is reflected on `famicom_data` at the 3rd `clk_sys` rising edge after it is first sampled (2 sync stages + 1 update).
- Reset values (reset_n low, asynchronous):
  - all sync/history FFs = 0
  - `shreg` = 8'hFF, so `famicom_data` = 1
  - `bit_count` = 0, `poll_strobe` = 0, turbo state = 0
- Reset mid-transfer: the transfer is aborted. After reset release, data stays 1 until the next latch.

Optional Feature:
- Macro: FAMICOM_TURBO_EN.
- Defined:
  - A free-running phase bit toggles after every TURBO_DIV `poll_strobe` events; the poll counter wraps at TURBO_DIV-1 and is reset to 0.
  - During load, effective A = `joy_in[4]` | (`turbo_in[0]` & phase); effective B = `joy_in[5]` | (`turbo_in[1]` & phase).
- Not defined: `turbo_in` is unused (lint waiver), there is no counter or phase logic, and A/B come from `joy_in` only.

Decomposition:
- Shared package `gigatron_input_pkg`:
  - localparams for host joystick bit indices (JOY_R..JOY_START)
  - serial-order indices (FC_A..FC_RIGHT)
  - FC_NBITS = 8
- Sub-module `input_sync_edge`: 2-FF synchroniser + history FF, outputs `level`, `rise`, `fall`. Instantiated twice, once for latch and once for pulse.

Test Plan:
- Reset: hold reset_n=0 with joy_in=8'hFF. Then famicom_data=1, bit_count=0, poll_strobe=0. Release reset with no latch: data stays 1.
- Basic read: joy_in=8'b0001_0001 (A+R); latch high 20 cycles, then low; 8 pulses. Serial data must be 0,1,1,1,1,1,1,0, and poll_strobe fires once.
- Over-read: after 8 pulses, apply 4 more. Data = FILL_BIT (1) each time, and bit_count stays 8.
- Pulse during latch: 3 pulses while latch high with joy_in=8'h80 (Start). After latch low, the first 3 bits are still A,B,Select = 1,1,1, and the 4th bit = 0.
- Latency/sync: a single raw pulse edge mid-`clk_sys` period changes famicom_data exactly 3 rising edges later. Jittering (asynchronous) latch/pulse timing over 1000 random reads never corrupts data.
- FAMICOM_TURBO_EN: turbo_in=2'b01, joy_in=0, TURBO_DIV=4, 16 polls. The A bit reads pressed on polls 5-8 and 13-16, and released otherwise. B is never pressed.

Source files
------------

// File: rtl/gigatron_input_pkg.sv
// Shared constants for the Gigatron controller path: host joystick bit indices
// and Famicom serial-order indices.
package gigatron_input_pkg;

    localparam int JOY_R      = 0;
    localparam int JOY_L      = 1;
    localparam int JOY_D      = 2;
    localparam int JOY_U      = 3;
    localparam int JOY_A      = 4;
    localparam int JOY_B      = 5;
    localparam int JOY_SELECT = 6;
    localparam int JOY_START  = 7;

    localparam int FC_A      = 0;
    localparam int FC_B      = 1;
    localparam int FC_SELECT = 2;
    localparam int FC_START  = 3;
    localparam int FC_UP     = 4;
    localparam int FC_DOWN   = 5;
    localparam int FC_LEFT   = 6;
    localparam int FC_RIGHT  = 7;

    localparam int FC_NBITS = 8;

    // Active-high host word to active-low serial-order word; A/B are passed
    // separately so the turbo logic can override them.
    function automatic logic [FC_NBITS-1:0] fc_pack(input logic [7:0] joy,
                                                    input logic       btn_a,
                                                    input logic       btn_b);
        logic [FC_NBITS-1:0] v;
        v            = '1;
        v[FC_A]      = ~btn_a;
        v[FC_B]      = ~btn_b;
        v[FC_SELECT] = ~joy[JOY_SELECT];
        v[FC_START]  = ~joy[JOY_START];
        v[FC_UP]     = ~joy[JOY_U];
        v[FC_DOWN]   = ~joy[JOY_D];
        v[FC_LEFT]   = ~joy[JOY_L];
        v[FC_RIGHT]  = ~joy[JOY_R];
        return v;
    endfunction

endpackage

// File: rtl/input_sync_edge.sv
// Two-flop synchroniser plus a history flop; flags rising and falling edges
// of the synchronised level.
module input_sync_edge (
    input  logic clk_sys,
    input  logic reset_n,
    input  logic async_in,
    output logic level,
    output logic rise,
    output logic fall
);

    logic r_meta;
    logic r_sync;
    logic r_hist;

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
            r_hist <= 1'b0;
        end else begin
            r_meta <= async_in;
            r_sync <= r_meta;
            r_hist <= r_sync;
        end
    end

    assign level = r_sync;
    assign rise  = r_sync & ~r_hist;
    assign fall  = ~r_sync & r_hist;

endmodule

// File: rtl/famicom_pad_emulator.sv
// Famicom/NES serial pad emulator driven by the Gigatron shell's latch/pulse.
// Turbo A/B buttons are built when FAMICOM_TURBO_EN is defined.
module famicom_pad_emulator
    import gigatron_input_pkg::*;
#(
    parameter logic FILL_BIT  = 1'b1,
    parameter int   TURBO_DIV = 4
) (
    input  logic       clk_sys,
    input  logic       reset_n,
    input  logic [7:0] joy_in,
    input  logic [1:0] turbo_in,
    input  logic       famicom_latch,
    input  logic       famicom_pulse,
    output logic       famicom_data,
    output logic [3:0] bit_count,
    output logic       poll_strobe
);

    logic w_latch_level;
    logic w_latch_rise;
    logic w_latch_fall;
    logic w_pulse_level;
    logic w_pulse_rise;
    logic w_pulse_fall;
    logic w_btn_a;
    logic w_btn_b;
    logic [FC_NBITS-1:0] w_load_val;

    logic [FC_NBITS-1:0] r_shreg;
    logic [3:0]          r_bit_count;
    logic                r_poll_strobe;

    input_sync_edge u_sync_latch (
        .clk_sys  (clk_sys),
        .reset_n  (reset_n),
        .async_in (famicom_latch),
        .level    (w_latch_level),
        .rise     (w_latch_rise),
        .fall     (w_latch_fall)
    );

    input_sync_edge u_sync_pulse (
        .clk_sys  (clk_sys),
        .reset_n  (reset_n),
        .async_in (famicom_pulse),
        .level    (w_pulse_level),
        .rise     (w_pulse_rise),
        .fall     (w_pulse_fall)
    );

`ifdef FAMICOM_TURBO_EN
    localparam int TCW = (TURBO_DIV > 1) ? $clog2(TURBO_DIV) : 1;

    logic [TCW-1:0] r_poll_cnt;
    logic           r_turbo_phase;
    logic           w_unused_sync;

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_poll_cnt    <= '0;
            r_turbo_phase <= 1'b0;
        end else if (w_latch_fall) begin
            if (r_poll_cnt == TCW'(TURBO_DIV - 1)) begin
                r_poll_cnt    <= '0;
                r_turbo_phase <= ~r_turbo_phase;
            end else begin
                r_poll_cnt <= r_poll_cnt + 1'b1;
            end
        end
    end

    assign w_btn_a       = joy_in[JOY_A] | (turbo_in[0] & r_turbo_phase);
    assign w_btn_b       = joy_in[JOY_B] | (turbo_in[1] & r_turbo_phase);
    assign w_unused_sync = w_latch_rise ^ w_pulse_level ^ w_pulse_fall;
`else
    logic w_unused_sync;

    assign w_btn_a       = joy_in[JOY_A];
    assign w_btn_b       = joy_in[JOY_B];
    assign w_unused_sync = w_latch_rise ^ w_pulse_level ^ w_pulse_fall
                         ^ (^turbo_in) ^ (TURBO_DIV == 0);
`endif

    assign w_load_val = fc_pack(joy_in, w_btn_a, w_btn_b);

    // The latch-fall cycle still loads, so a coincident pulse edge is dropped.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_shreg       <= '1;
            r_bit_count   <= 4'd0;
            r_poll_strobe <= 1'b0;
        end else begin
            r_poll_strobe <= w_latch_fall;
            if (w_latch_level || w_latch_fall) begin
                r_shreg     <= w_load_val;
                r_bit_count <= 4'd0;
            end else if (w_pulse_rise) begin
                r_shreg <= {FILL_BIT, r_shreg[FC_NBITS-1:1]};
                if (r_bit_count != 4'(FC_NBITS))
                    r_bit_count <= r_bit_count + 4'd1;
            end
        end
    end

    assign famicom_data = r_shreg[0];
    assign bit_count    = r_bit_count;
    assign poll_strobe  = r_poll_strobe;

endmodule

// File: tb/tb_famicom_pad_emulator.sv
// Directed bench for famicom_pad_emulator; define FAMICOM_TURBO_EN to also
// expect turbo behaviour on the A button.
module tb_famicom_pad_emulator;

    logic       clk_sys;
    logic       reset_n;
    logic [7:0] joy_in;
    logic [1:0] turbo_in;
    logic       famicom_latch;
    logic       famicom_pulse;
    logic       famicom_data;
    logic [3:0] bit_count;
    logic       poll_strobe;

    int n_tests = 0;
    int n_fail  = 0;
    int n_poll_cycles = 0;

    famicom_pad_emulator #(.FILL_BIT(1'b1), .TURBO_DIV(4)) dut (
        .clk_sys       (clk_sys),
        .reset_n       (reset_n),
        .joy_in        (joy_in),
        .turbo_in      (turbo_in),
        .famicom_latch (famicom_latch),
        .famicom_pulse (famicom_pulse),
        .famicom_data  (famicom_data),
        .bit_count     (bit_count),
        .poll_strobe   (poll_strobe)
    );

    initial begin
        clk_sys = 1'b0;
        forever #5 clk_sys = ~clk_sys;
    end

    always @(posedge clk_sys) if (poll_strobe === 1'b1) n_poll_cycles <= n_poll_cycles + 1;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Hand-written serial order: A B Sel Start Up Down Left Right, active-low.
    function automatic logic [7:0] serial_word(input logic [7:0] j);
        return ~{j[0], j[1], j[2], j[3], j[7], j[6], j[5], j[4]};
    endfunction

    task automatic do_latch(input logic [7:0] joy, input int hi);
        joy_in = joy;
        famicom_latch = 1'b1;
        #(hi);
        famicom_latch = 1'b0;
        #40;
    endtask

    task automatic do_pulse(input int hi, input int lo);
        famicom_pulse = 1'b1;
        #(hi);
        famicom_pulse = 1'b0;
        #(lo);
    endtask

    logic [7:0] exp_word;
    logic [7:0] got_word;
    int         polls0;
    logic       exp_a;

    initial begin
        reset_n       = 1'b0;
        joy_in        = 8'hFF;
        turbo_in      = 2'b00;
        famicom_latch = 1'b0;
        famicom_pulse = 1'b0;

        // Reset state
        #50;
        @(negedge clk_sys);
        check("reset_data", {7'd0, famicom_data}, 8'd1);
        check("reset_count", {4'd0, bit_count}, 8'd0);
        check("reset_poll", {7'd0, poll_strobe}, 8'd0);
        reset_n = 1'b1;
        #100;
        check("post_reset_data", {7'd0, famicom_data}, 8'd1);

        // Basic read A+R
        polls0 = n_poll_cycles;
        do_latch(8'b0001_0001, 200);
        exp_word = 8'b1000_0001;
        for (int i = 0; i < 8; i++) begin
            check($sformatf("basic_bit%0d", i), {7'd0, famicom_data}, {7'd0, ~exp_word[i]});
            check($sformatf("basic_cnt%0d", i), {4'd0, bit_count}, 8'(i));
            do_pulse(40, 40);
        end
        check("basic_cnt8", {4'd0, bit_count}, 8'd8);
        check("basic_polls", 8'(n_poll_cycles - polls0), 8'd1);

        // Over-read
        for (int i = 0; i < 4; i++) begin
            do_pulse(40, 40);
            check($sformatf("over_data%0d", i), {7'd0, famicom_data}, 8'd1);
            check($sformatf("over_cnt%0d", i), {4'd0, bit_count}, 8'd8);
        end

        // Pulses while latch is high are ignored
        joy_in = 8'h80;
        famicom_latch = 1'b1;
        #50;
        for (int i = 0; i < 3; i++) do_pulse(40, 40);
        check("latch_hi_cnt", {4'd0, bit_count}, 8'd0);
        famicom_latch = 1'b0;
        #40;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("plh_bit%0d", i), {7'd0, famicom_data}, (i == 3) ? 8'd0 : 8'd1);
            do_pulse(40, 40);
        end

        // Latency: raw pulse edge at a falling clock edge shows on the 3rd rise
        do_latch(8'h10, 100);
        @(negedge clk_sys);
        check("lat_pre", {7'd0, famicom_data}, 8'd0);
        famicom_pulse = 1'b1;
        @(posedge clk_sys); #1;
        check("lat_e1", {7'd0, famicom_data}, 8'd0);
        @(posedge clk_sys); #1;
        check("lat_e2", {7'd0, famicom_data}, 8'd0);
        @(posedge clk_sys); #1;
        check("lat_e3", {7'd0, famicom_data}, 8'd1);
        check("lat_cnt", {4'd0, bit_count}, 8'd1);
        @(negedge clk_sys);
        famicom_pulse = 1'b0;
        #40;

        // Jittered reads, joy changes mid-latch and must be tracked
        for (int r = 0; r < 1000; r++) begin
            joy_in = 8'($urandom);
            famicom_latch = 1'b1;
            #(15 + $urandom_range(0, 7));
            joy_in = 8'($urandom);
            exp_word = serial_word(joy_in);
            #(25 + $urandom_range(0, 7));
            famicom_latch = 1'b0;
            #(35 + $urandom_range(0, 7));
            for (int i = 0; i < 8; i++) begin
                @(negedge clk_sys);
                got_word[i] = famicom_data;
                #($urandom_range(0, 9));
                do_pulse(25 + $urandom_range(0, 7), 25 + $urandom_range(0, 7));
            end
            check($sformatf("rand_read%0d", r), got_word, exp_word);
        end
        @(negedge clk_sys);

        // Reset mid-transfer aborts the read
        do_latch(8'hFF, 100);
        do_pulse(40, 40);
        do_pulse(40, 40);
        check("mid_cnt", {4'd0, bit_count}, 8'd2);
        check("mid_data", {7'd0, famicom_data}, 8'd0);
        reset_n = 1'b0;
        #20;
        check("mid_rst_data", {7'd0, famicom_data}, 8'd1);
        check("mid_rst_cnt", {4'd0, bit_count}, 8'd0);
        @(negedge clk_sys);
        reset_n = 1'b1;
        #100;
        check("mid_post_data", {7'd0, famicom_data}, 8'd1);

        // Turbo A: pressed on polls 5-8 and 13-16 only when the feature is built
        turbo_in = 2'b01;
        for (int p = 1; p <= 16; p++) begin
`ifdef FAMICOM_TURBO_EN
            exp_a = (((p - 1) / 4) % 2) == 1;
`else
            exp_a = 1'b0;
`endif
            do_latch(8'h00, 60);
            check($sformatf("turbo_a%0d", p), {7'd0, famicom_data}, {7'd0, ~exp_a});
            do_pulse(40, 40);
            check($sformatf("turbo_b%0d", p), {7'd0, famicom_data}, 8'd1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
